benes_ctrl_decoder: RTL

BENES_CTRL_DECODER -- requirements
Module: benes_ctrl_decoder

---
 rtl/benes_ctrl_decoder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/benes_ctrl_decoder.sv
// rtl/benes_ctrl_decoder.sv - Benes control word to destination permutation decoder
//
// Takes one Benes switch-setting word and, one stage per cycle, pushes the
// identity tag vector through the network. It then reports, for every input
// port, the output port that the input reaches.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   in_valid     control_bit holds a job
//   in_ready     idle and able to take a job
//   control_bit  switch settings, bit s*HALF+k = switch k of stage s, 1 = cross
//   out_valid    perm holds a finished result
//   out_ready    consumer takes the result
//   perm         perm[i] = output port reached by input i
//   perm_inv     perm_inv[L] = input port that lands on output L
//                (present only with BENES_DECODE_INV_EN defined)
//
// Build option: define BENES_DECODE_INV_EN to add the perm_inv output.
module benes_ctrl_decoder #(
   parameter int SIZE     = 32,
   parameter int DWIDTH   = 16,
   localparam int TAGWIDTH = $clog2(SIZE),
   localparam int STAGES   = 2 * TAGWIDTH - 1,
   localparam int HALF     = SIZE / 2,
   localparam int BITWIDTH = STAGES * HALF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BITWIDTH-1:0] control_bit,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [TAGWIDTH-1:0] perm [SIZE]
`ifdef BENES_DECODE_INV_EN
   ,
   output logic [TAGWIDTH-1:0] perm_inv [SIZE]
`endif
);

   localparam int CW = $clog2(STAGES) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [BITWIDTH-1:0] ctrl;
   logic [CW-1:0]       stage;
   logic                last_stage;
   int                  stage_i;
   logic [TAGWIDTH-1:0] lane     [SIZE];
   logic [TAGWIDTH-1:0] swapped  [SIZE];
   logic [TAGWIDTH-1:0] lane_nxt [SIZE];

   // DWIDTH carries no data here; it only mirrors the benes module's parameters.
   if (DWIDTH < 1) begin : g_dwidth_parity
   end

   // Source position, before the interconnect that follows stage s, of the
   // tag that ends up at position q. The first half of the network
   // unshuffles in blocks that shrink each stage. The second half shuffles
   // in blocks that grow back to SIZE. The last stage has no interconnect.
   function automatic int src_pos(input int s, input int q);
      int blk;
      int half;
      int base;
      int l;
      blk  = SIZE;
      half = 1;
      base = 0;
      l    = 0;
      src_pos = q;
      if (s < TAGWIDTH - 1) begin
         blk  = SIZE >> s;
         half = blk / 2;
         base = q - (q % blk);
         l    = q % blk;
         src_pos = (l < half) ? base + 2 * l : base + 2 * (l - half) + 1;
      end else if (s < STAGES - 1) begin
         blk  = 1 << (s - TAGWIDTH + 3);
         half = blk / 2;
         base = q - (q % blk);
         l    = q % blk;
         src_pos = base + (l >> 1) + (l & 1) * half;
      end
   endfunction

   assign last_stage = (stage == CW'(STAGES - 1));

   // One network stage: switch exchange followed by the stage's interconnect.
   always_comb begin
      stage_i = int'(stage);
      for (int j = 0; j < SIZE; j++) begin
         swapped[j]  = lane[j];
         lane_nxt[j] = lane[j];
      end
      if (stage_i < STAGES) begin
         for (int k = 0; k < HALF; k++) begin
            if (ctrl[stage_i * HALF + k]) begin
               swapped[2 * k]     = lane[2 * k + 1];
               swapped[2 * k + 1] = lane[2 * k];
            end
         end
      end
      for (int q = 0; q < SIZE; q++) begin
         lane_nxt[q] = swapped[src_pos(stage_i, q)];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            if (last_stage) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl  <= '0;
         stage <= '0;
         for (int j = 0; j < SIZE; j++) begin
            lane[j] <= TAGWIDTH'(j);
            perm[j] <= '0;
`ifdef BENES_DECODE_INV_EN
            perm_inv[j] <= '0;
`endif
         end
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  ctrl  <= control_bit;
                  stage <= '0;
                  for (int j = 0; j < SIZE; j++) lane[j] <= TAGWIDTH'(j);
               end
            end
            RUN: begin
               for (int j = 0; j < SIZE; j++) lane[j] <= lane_nxt[j];
               if (last_stage) begin
                  // Final lane L carries the tag of the input that reaches output L.
                  for (int l = 0; l < SIZE; l++) begin
                     perm[lane_nxt[l]] <= TAGWIDTH'(l);
`ifdef BENES_DECODE_INV_EN
                     perm_inv[l] <= lane_nxt[l];
`endif
                  end
               end else begin
                  stage <= stage + CW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
